// File: rtl/tl_pkg.sv
// Shared light codes and phase encodings
// for the traffic-light phase controller.
package tl_pkg;

  typedef enum logic [1:0] {
    LT_GREEN  = 2'b00,
    LT_YELLOW = 2'b01,
    LT_RED    = 2'b10
  } light_t;

  typedef enum logic [1:0] {
    ST_GREEN  = 2'b00,
    ST_YELLOW = 2'b01,
    ST_ALLRED = 2'b10
  } state_t;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tl_timer.sv
// Phase timer: clear, increment, saturate
// at SAT, with a terminal-count flag.
module tl_timer #(
  parameter int W   = 4,
  parameter int SAT = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         tc
);

  localparam logic [W-1:0] SAT_V = W'(SAT);

  always_ff @(posedge clk) begin
    if (reset || clr)
      cnt <= '0;
    else if (inc && cnt != SAT_V)
      cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == SAT_V);

endmodule

// File: rtl/tl_phase_ctrl.sv
// Round-robin traffic-light phase controller
// (GREEN -> YELLOW -> ALL_RED -> next GREEN).
module tl_phase_ctrl
  import tl_pkg::*;
#(
  parameter int N_DIR      = 4,
  parameter int GREEN_MIN  = 4,
  parameter int GREEN_MAX  = 16,
  parameter int YELLOW_CYC = 2,
  parameter int ALLRED_CYC = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_DIR-1:0]         T,
  output logic [2*N_DIR-1:0]       light,
  output logic [$clog2(N_DIR)-1:0] cur_dir,
  output logic                     switch_p
);

  localparam int DW = $clog2(N_DIR);
  localparam int TMAX =
    max3(GREEN_MAX, YELLOW_CYC, ALLRED_CYC) - 1;
  localparam int TW = $clog2(TMAX + 1);

  state_t          state;
  state_t          state_nx;
  logic [DW-1:0]   next_dir;
  logic [DW-1:0]   srch_dir;
  logic [TW-1:0]   tmr;
  logic            tmr_tc;
  logic            tmr_clr;
  logic            tmr_inc;
  logic            other_req;
  logic            found;
  logic            g_max;
  logic            g_exit;
  logic            y_done;
  logic            a_done;
  int              j;

  tl_timer #(
    .W   (TW),
    .SAT (TMAX)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (tmr_clr),
    .inc   (tmr_inc),
    .cnt   (tmr),
    .tc    (tmr_tc)
  );

  always_comb begin
    other_req = 1'b0;
    for (int i = 0; i < N_DIR; i++)
      if (DW'(i) != cur_dir)
        other_req = other_req | T[i];
  end

  // First requesting direction after cur_dir,
  // wrapping from N_DIR-1 back to 0.
  always_comb begin
    found    = 1'b0;
    srch_dir = cur_dir;
    j        = 0;
    for (int k = 1; k < N_DIR; k++) begin
      j = int'(cur_dir) + k;
      if (j >= N_DIR)
        j = j - N_DIR;
      if (!found && T[j]) begin
        found    = 1'b1;
        srch_dir = DW'(j);
      end
    end
  end

  assign g_max  = tmr_tc |
                  (tmr == TW'(GREEN_MAX - 1));
  assign g_exit = (tmr >= TW'(GREEN_MIN - 1)) &&
                  other_req &&
                  (!T[cur_dir] || g_max);
  assign y_done = (tmr == TW'(YELLOW_CYC - 1));
  assign a_done = (tmr == TW'(ALLRED_CYC - 1));

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_GREEN:  if (g_exit) state_nx = ST_YELLOW;
      ST_YELLOW: if (y_done) state_nx = ST_ALLRED;
      ST_ALLRED: if (a_done) state_nx = ST_GREEN;
      default:   state_nx = ST_GREEN;
    endcase
    tmr_clr = (state_nx != state);
    tmr_inc = !((state == ST_GREEN) && g_max);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_GREEN;
      cur_dir  <= '0;
      next_dir <= '0;
      switch_p <= 1'b0;
    end else begin
      state    <= state_nx;
      switch_p <= (state == ST_ALLRED) && a_done;
      if (state == ST_GREEN && g_exit)
        next_dir <= srch_dir;
      if (state == ST_ALLRED && a_done)
        cur_dir <= next_dir;
    end
  end

  always_comb begin
    light = '0;
    for (int i = 0; i < N_DIR; i++) begin
      unique case (1'b1)
        (state == ST_GREEN &&
         DW'(i) == cur_dir):
          light[2*i +: 2] = LT_GREEN;
        (state == ST_YELLOW &&
         DW'(i) == cur_dir):
          light[2*i +: 2] = LT_YELLOW;
        default:
          light[2*i +: 2] = LT_RED;
      endcase
    end
  end

endmodule
